mb_scheduler_luma16x16: RTL and testbench

- Frame-level sequencer for the luma 16x16 macroblock extractor.
- Walks macroblocks in raster order and drives the extractor's enable and mbnumber.
- Waits out the extractor's fetch latency, then presents each macroblock to the intra-prediction engine with a valid/ready handshake.
- Reports frame completion and boundary flags (first row/column) so downstream logic substitutes 128 for missing neighbours.

---
 rtl/mb_scheduler_luma16x16_pkg.sv | 26 ++
 rtl/mb_scheduler_luma16x16_if.sv | 24 ++
 rtl/mb_scheduler_luma16x16_raster.sv | 81 ++++++++
 rtl/mb_scheduler_luma16x16.sv | 155 +++++++++++++++
 tb/tb_mb_scheduler_luma16x16.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mb_scheduler_luma16x16_pkg.sv
// Shared types and geometry helpers for the luma 16x16 macroblock scheduler.
package intra_pred_pkg;

  localparam int MBNUM_W = 13;
  localparam int MBXY_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  function automatic int calc_mbs_x(input int length, input int mb_size_l);
    return length / mb_size_l;
  endfunction

  function automatic int calc_mbs_y(input int width, input int mb_size_w);
    return width / mb_size_w;
  endfunction

  function automatic int calc_mb_total(input int mbs_x, input int mbs_y);
    return mbs_x * mbs_y;
  endfunction

endpackage

// File: rtl/mb_scheduler_luma16x16_if.sv
// Extractor / prediction-engine side bus of the macroblock scheduler.
// master = scheduler, slave = consumer (extractor + intra-prediction engine).
interface mb_scheduler_luma16x16_if;
  import intra_pred_pkg::*;

  logic               ext_enable;
  logic [MBNUM_W-1:0] mbnumber;
  logic [MBXY_W-1:0]  mb_x;
  logic [MBXY_W-1:0]  mb_y;
  logic               first_row;
  logic               first_col;
  logic               mb_valid;
  logic               pred_ready;

  modport master (
    output ext_enable, mbnumber, mb_x, mb_y, first_row, first_col, mb_valid,
    input  pred_ready
  );

  modport slave (
    input  ext_enable, mbnumber, mb_x, mb_y, first_row, first_col, mb_valid,
    output pred_ready
  );
endinterface

// File: rtl/mb_scheduler_luma16x16_raster.sv
// Raster position counter: mb_x/mb_y/mbnumber with registered boundary flags.
// mbnumber is kept as a running count so no multiplier is needed.
module mb_raster_counter
  import intra_pred_pkg::*;
#(
  parameter int MBS_X = 80,
  parameter int MBS_Y = 45
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               advance_i,
  output logic [MBNUM_W-1:0] mbnumber_o,
  output logic [MBXY_W-1:0]  mb_x_o,
  output logic [MBXY_W-1:0]  mb_y_o,
  output logic               first_row_o,
  output logic               first_col_o,
  output logic               last_mb_o
);

  localparam logic [MBXY_W-1:0]  X_LAST  = MBXY_W'(MBS_X - 1);
  localparam logic [MBNUM_W-1:0] MB_LAST = MBNUM_W'(MBS_X * MBS_Y - 1);

  logic [MBNUM_W-1:0] mbnumber_q, mbnumber_d;
  logic [MBXY_W-1:0]  mb_x_q, mb_x_d, mb_y_q, mb_y_d;
  logic               first_row_q, first_row_d, first_col_q, first_col_d;

  // Next raster position: clear to origin, step one macroblock, or hold.
  always_comb begin
    mbnumber_d  = mbnumber_q;
    mb_x_d      = mb_x_q;
    mb_y_d      = mb_y_q;
    first_row_d = first_row_q;
    first_col_d = first_col_q;
    if (clear_i) begin
      mbnumber_d  = '0;
      mb_x_d      = '0;
      mb_y_d      = '0;
      first_row_d = 1'b1;
      first_col_d = 1'b1;
    end else if (advance_i) begin
      if (mb_x_q == X_LAST) begin
        mb_x_d = '0;
        mb_y_d = mb_y_q + MBXY_W'(1);
      end else begin
        mb_x_d = mb_x_q + MBXY_W'(1);
        mb_y_d = mb_y_q;
      end
      mbnumber_d  = mbnumber_q + MBNUM_W'(1);
      first_row_d = (mb_y_d == MBXY_W'(0));
      first_col_d = (mb_x_d == MBXY_W'(0));
    end else begin
      mbnumber_d = mbnumber_q;
    end
  end

  // Position and boundary flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mbnumber_q  <= '0;
      mb_x_q      <= '0;
      mb_y_q      <= '0;
      first_row_q <= 1'b0;
      first_col_q <= 1'b0;
    end else begin
      mbnumber_q  <= mbnumber_d;
      mb_x_q      <= mb_x_d;
      mb_y_q      <= mb_y_d;
      first_row_q <= first_row_d;
      first_col_q <= first_col_d;
    end
  end

  assign mbnumber_o  = mbnumber_q;
  assign mb_x_o      = mb_x_q;
  assign mb_y_o      = mb_y_q;
  assign first_row_o = first_row_q;
  assign first_col_o = first_col_q;
  assign last_mb_o   = (mbnumber_q == MB_LAST);

endmodule

// File: rtl/mb_scheduler_luma16x16.sv
// Frame-level sequencer for the luma 16x16 macroblock extractor.
// Optional stall counter output enabled by defining MB_SCHED_PERF_EN.
module mb_scheduler_luma16x16
  import intra_pred_pkg::*;
#(
  parameter int LENGTH      = 1280,
  parameter int WIDTH       = 720,
  parameter int MB_SIZE_L   = 16,
  parameter int MB_SIZE_W   = 16,
  parameter int EXTRACT_LAT = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  mb_scheduler_luma16x16_if.master  mbif,
  output logic                      busy,
  output logic                      frame_done
`ifdef MB_SCHED_PERF_EN
  ,
  output logic [31:0]               stall_cycles
`endif
);

  localparam int MBS_X    = calc_mbs_x(LENGTH, MB_SIZE_L);
  localparam int MBS_Y    = calc_mbs_y(WIDTH, MB_SIZE_W);
  localparam int MB_TOTAL = calc_mb_total(MBS_X, MBS_Y);
  localparam int LAT_W    = (EXTRACT_LAT > 1) ? $clog2(EXTRACT_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(EXTRACT_LAT - 1);

  // The frame must tile exactly into macroblocks and fit the index widths.
  if ((LENGTH % MB_SIZE_L) != 0 || (WIDTH % MB_SIZE_W) != 0) begin : g_bad_tiling
    $error("frame size is not a multiple of the macroblock size");
  end
  if (MB_TOTAL >= 8192 || MBS_X > 256 || MBS_Y > 256 || EXTRACT_LAT < 1) begin : g_bad_range
    $error("macroblock count or extract latency out of range");
  end

  sched_state_e     state_q, state_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             cnt_clear_s, cnt_adv_s, last_mb_s;
  logic             ext_enable_q, mb_valid_q, busy_q, frame_done_q;

  mb_raster_counter #(
    .MBS_X (MBS_X),
    .MBS_Y (MBS_Y)
  ) u_raster (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (cnt_clear_s),
    .advance_i   (cnt_adv_s),
    .mbnumber_o  (mbif.mbnumber),
    .mb_x_o      (mbif.mb_x),
    .mb_y_o      (mbif.mb_y),
    .first_row_o (mbif.first_row),
    .first_col_o (mbif.first_col),
    .last_mb_o   (last_mb_s)
  );

  // State and fetch-latency counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

  // Next-state logic and raster counter control.
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    cnt_clear_s = 1'b0;
    cnt_adv_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = FETCH;
          lat_d       = '0;
          cnt_clear_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (lat_q == LAT_MAX) begin
          state_d = VALID;
          lat_d   = '0;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      VALID: begin
        if (mbif.pred_ready) begin
          if (last_mb_s) begin
            state_d = DONE;
          end else begin
            state_d   = FETCH;
            cnt_adv_s = 1'b1;
          end
        end else begin
          state_d = VALID;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        lat_d   = '0;
      end
    endcase
  end

  // Status outputs registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      ext_enable_q <= 1'b0;
      mb_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      ext_enable_q <= (state_d == FETCH);
      mb_valid_q   <= (state_d == VALID);
      busy_q       <= (state_d != IDLE);
      frame_done_q <= (state_d == DONE);
    end
  end

  assign mbif.ext_enable = ext_enable_q;
  assign mbif.mb_valid   = mb_valid_q;
  assign busy            = busy_q;
  assign frame_done      = frame_done_q;

`ifdef MB_SCHED_PERF_EN
  logic [31:0] stall_q;

  // Saturating count of offered-but-not-accepted cycles within a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= 32'd0;
    end else if (state_q == IDLE && start) begin
      stall_q <= 32'd0;
    end else if (state_q == VALID && !mbif.pred_ready && stall_q != 32'hFFFF_FFFF) begin
      stall_q <= stall_q + 32'd1;
    end else begin
      stall_q <= stall_q;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_mb_scheduler_luma16x16.sv
// Self-checking bench: scoreboard of expected macroblocks popped on acceptance.
module tb_mb_scheduler_luma16x16;

  localparam int LAT = 3;

  typedef struct {
    int mbn;
    int x;
    int y;
    int fr;
    int fc;
    int hold;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_s = 1'b0, start_b = 1'b0;
  logic busy_s, fd_s, busy_b, fd_b;
  int   cyc = 0;
  int   n_chk = 0, n_err = 0;

  exp_t sb[$];
  exp_t sb_big[$];

  int en_run = 0, valid_run = 0, hold_mbn = 0, stall_seen = 0;
  int acc_count = 0, fd_count = 0, last_acc_cyc = 0;
  int start_cyc = 0, first_pending = 0;
  int big_acc = 0, big_last_mbn = 0, big_last_x = 0, big_last_y = 0;
  int big_last_cyc = 0, big_fd_cyc = 0;

  mb_scheduler_luma16x16_if sif ();
  mb_scheduler_luma16x16_if bif ();

`ifdef MB_SCHED_PERF_EN
  logic [31:0] stall_s, stall_b;
`endif

  mb_scheduler_luma16x16 #(
    .LENGTH(64), .WIDTH(32), .MB_SIZE_L(16), .MB_SIZE_W(16), .EXTRACT_LAT(LAT)
  ) u_small (
    .clk(clk), .reset(reset), .start(start_s), .mbif(sif),
    .busy(busy_s), .frame_done(fd_s)
`ifdef MB_SCHED_PERF_EN
    , .stall_cycles(stall_s)
`endif
  );

  mb_scheduler_luma16x16 u_big (
    .clk(clk), .reset(reset), .start(start_b), .mbif(bif),
    .busy(busy_b), .frame_done(fd_b)
`ifdef MB_SCHED_PERF_EN
    , .stall_cycles(stall_b)
`endif
  );

  assign bif.pred_ready = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int stall_mb, input int stall_len);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.mbn  = i;
      e.x    = i % 4;
      e.y    = i / 4;
      e.fr   = (e.y == 0) ? 1 : 0;
      e.fc   = (e.x == 0) ? 1 : 0;
      e.hold = (i == stall_mb) ? stall_len + 1 : 1;
      sb.push_back(e);
    end
  endtask

  task automatic start_frame(input int stall_mb, input int stall_len);
    push_frame(stall_mb, stall_len);
    start_s       = 1'b1;
    start_cyc     = cyc;
    first_pending = 1;
    step();
    start_s = 1'b0;
  endtask

  task automatic wait_done(input int stall_mb, input int stall_len, input string tag);
    bit done = 1'b0;
    bit stalled = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      step();
      if (stall_mb >= 0 && !stalled && sif.mb_valid && sif.mbnumber == stall_mb) begin
        stalled = 1'b1;
        sif.pred_ready = 1'b0;
        repeat (stall_len) step();
        sif.pred_ready = 1'b1;
      end
      if (fd_s) done = 1'b1;
    end
    if (!done) chk(tag, 32'd0, 32'd1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_flags"}, {sif.ext_enable, sif.mb_valid, busy_s, fd_s, sif.first_row, sif.first_col}, 32'd0);
    chk({tag, "_mbn"}, sif.mbnumber, 32'd0);
    chk({tag, "_xy"}, {sif.mb_x, sif.mb_y}, 32'd0);
`ifdef MB_SCHED_PERF_EN
    chk({tag, "_stall"}, stall_s, 32'd0);
`endif
  endtask

  // Small-DUT monitor: latency, hold, enable counts and scoreboard pops.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (!busy_s) begin
        en_run    = 0;
        valid_run = 0;
      end
      if (sif.ext_enable) en_run++;
      if (sif.mb_valid) begin
        if (valid_run == 0) begin
          chk("en_cycles", en_run, LAT);
          en_run = 0;
          if (first_pending != 0) begin
            chk("start_lat", cyc - start_cyc, 32'd4);
            first_pending = 0;
          end
        end else begin
          chk("hold_mbn", sif.mbnumber, hold_mbn);
        end
        chk("en_in_valid", sif.ext_enable, 32'd0);
        valid_run++;
        hold_mbn = sif.mbnumber;
        if (!sif.pred_ready) begin
          stall_seen++;
        end else begin
          if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("mbn", sif.mbnumber, e.mbn);
            chk("mb_x", sif.mb_x, e.x);
            chk("mb_y", sif.mb_y, e.y);
            chk("first_row", sif.first_row, e.fr);
            chk("first_col", sif.first_col, e.fc);
            chk("hold_len", valid_run, e.hold);
          end
          valid_run    = 0;
          acc_count++;
          last_acc_cyc = cyc;
        end
      end
      if (fd_s) begin
        fd_count++;
        chk("fd_after_acc", cyc - last_acc_cyc, 32'd1);
      end
    end
  end

  // Default-size DUT monitor.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (bif.mb_valid && bif.pred_ready) begin
        if (sb_big.size() == 0) begin
          chk("big_underflow", 32'd1, 32'd0);
        end else begin
          e = sb_big.pop_front();
          chk("big_mbn", bif.mbnumber, e.mbn);
          chk("big_xy", {bif.mb_x, bif.mb_y}, {e.x[7:0], e.y[7:0]});
        end
        big_acc++;
        big_last_mbn = bif.mbnumber;
        big_last_x   = bif.mb_x;
        big_last_y   = bif.mb_y;
        big_last_cyc = cyc;
      end
      if (fd_b) big_fd_cyc = cyc;
    end
  end

  initial begin
    int acc0, fd0;
    exp_t e;
    bit hit;
    sif.pred_ready = 1'b1;
    repeat (3) step();
    check_zero("reset");
    reset = 1'b0;
    step();

    // Frame 1: ready tied high, raster order, flags, period.
    acc0 = acc_count;
    start_frame(-1, 0);
    wait_done(-1, 0, "f1_timeout");
    step();
    chk("f1_accepts", acc_count - acc0, 32'd8);
    chk("f1_period", last_acc_cyc - start_cyc, 32'd32);
    chk("f1_fd", fd_count, 32'd1);
    chk("f1_idle", busy_s, 32'd0);

    // Frame 2: backpressure at mbnumber 2.
    stall_seen = 0;
    start_frame(2, 5);
    wait_done(2, 5, "f2_timeout");
    step();
    chk("f2_stall_seen", stall_seen, 32'd5);
`ifdef MB_SCHED_PERF_EN
    chk("f2_stall_cycles", stall_s, 32'd5);
`endif

    // Frame 3: reset while fetching mbnumber 5.
    start_frame(-1, 0);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      step();
      if (sif.ext_enable && sif.mbnumber == 13'd5) hit = 1'b1;
    end
    chk("f3_reach5", hit, 32'd1);
    fd0   = fd_count;
    reset = 1'b1;
    step();
    check_zero("midreset");
    sb.delete();
    reset = 1'b0;
    repeat (3) step();
    chk("f3_no_fd", fd_count, fd0);
    chk("f3_idle", busy_s, 32'd0);
    start_frame(-1, 0);
    wait_done(-1, 0, "f3r_timeout");
    step();

    // Frame 4: starts during VALID and DONE are ignored.
    fd0 = fd_count;
    push_frame(-1, 0);
    start_s = 1'b1;
    start_cyc = cyc;
    first_pending = 1;
    step();
    start_s = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      step();
      if (sif.mb_valid && sif.mbnumber == 13'd1) hit = 1'b1;
    end
    chk("f4_reach1", hit, 32'd1);
    start_s = 1'b1;
    step();
    start_s = 1'b0;
    wait_done(-1, 0, "f4_timeout");
    start_s = 1'b1;
    step();
    start_s = 1'b0;
    chk("f4_done_start_ignored", busy_s, 32'd0);
    chk("f4_one_fd", fd_count - fd0, 32'd1);
    start_frame(-1, 0);
    wait_done(-1, 0, "f5_timeout");
    step();
    chk("f5_fd", fd_count - fd0, 32'd2);
    chk("sb_empty", sb.size(), 32'd0);

    // Default geometry full frame.
    for (int i = 0; i < 3600; i++) begin
      e.mbn = i; e.x = i % 80; e.y = i / 80; e.fr = 0; e.fc = 0; e.hold = 1;
      sb_big.push_back(e);
    end
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 16000 && !hit; i++) begin
      step();
      if (fd_b) hit = 1'b1;
    end
    chk("big_done", hit, 32'd1);
    step();
    chk("big_accepts", big_acc, 32'd3600);
    chk("big_last_mbn", big_last_mbn, 32'd3599);
    chk("big_last_x", big_last_x, 32'd79);
    chk("big_last_y", big_last_y, 32'd44);
    chk("big_fd_cyc", big_fd_cyc - big_last_cyc, 32'd1);
    chk("big_sb_empty", sb_big.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
